strobe_txn_responder: RTL and testbench
=======================================

Name: strobe_txn_responder

Overview:
- Receive-side checker and responder for the wr/rd strobe protocol driven by the bench stimulus tasks.
- Write transactions are single-cycle `wr` pulses. Read transactions are `rd` held high for exactly RD_LEN cycles.
- Counts completed transactions and flags protocol violations.
- Issues a one-cycle `done` pulse once NUM_WR writes and NUM_RD reads have completed and both lines have gone quiet.
- Sits between the strobe initiator and the downstream sequencer that waits on `done`.

Parameters:
- NUM_WR, 5, write pulses required per session
- NUM_RD, 5, read bursts required per session
- RD_LEN, 2, exact cycles `rd` must stay high per burst
- TIMEOUT, 64, maximum cycles in ACTIVE without a strobe edge
- CNT_W, 8, width of counters and timeout counter; must hold max(NUM_WR, NUM_RD, TIMEOUT)

Ports:
- clk, in, 1, clock; all logic on posedge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; opens a session
- wr, in, 1, write strobe
- rd, in, 1, read strobe
- done, out, 1, one-cycle pulse at session completion
- busy, out, 1, high in ACTIVE and DRAIN
- wr_cnt, out, CNT_W, completed writes this session
- rd_cnt, out, CNT_W, completed reads this session
- err, out, 4, sticky flags: [0] wr_len, [1] rd_len, [2] extra, [3] timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - done=0, busy=0, wr_cnt=0, rd_cnt=0, err=0.
  - All internal edge/run/timeout registers cleared.
- Sampling:
  - Inputs are registered once for edge detection.
  - Edges are computed from the current and previous sample.
- IDLE:
  - wr/rd are ignored.
  - start=1 → ACTIVE next cycle; clears wr_cnt, rd_cnt, err and the timeout counter.
- ACTIVE:
  - Write completion:
    - A `wr` rise increments wr_cnt.
    - If `wr` is still high on the following cycle, set err[0]; the count still stands.
  - Read completion:
    - rd_run counts consecutive high cycles of `rd`.
    - On `rd` fall: if rd_run==RD_LEN, increment rd_cnt; otherwise set err[1] and leave rd_cnt unchanged.
    - rd_run saturates at RD_LEN+1.
  - Extra transactions: a `wr` rise with wr_cnt==NUM_WR, or an `rd` rise with rd_cnt==NUM_RD, sets err[2] and does not increment.
  - Simultaneous events: a `wr` rise and an `rd` fall in the same cycle are both processed.
  - Timeout:
    - The timeout counter resets on any wr/rd edge and increments otherwise.
    - Reaching TIMEOUT sets err[3] → ERROR.
  - Quota: when wr_cnt==NUM_WR and rd_cnt==NUM_RD (post-update) → DRAIN.
- DRAIN:
  - Wait until wr==0 and rd==0 in the same sampled cycle.
  - Then → DONE.
  - Any rise seen here sets err[2] and stays in DRAIN.
- DONE:
  - done=1 for exactly one cycle.
  - → IDLE. Counters hold their final values until the next start.
- ERROR:
  - Entered from ACTIVE on timeout, or from any state when err[0..2] is set while in ACTIVE/DRAIN.
  - busy=0, done is never asserted; err is held.
  - start → ACTIVE (clears everything, as from IDLE).
- Priority:
  - start is honoured only in IDLE/ERROR.
  - The error transition wins over the quota transition in the same cycle.
- Latency:
  - done asserts 1 cycle after the quiet-lines cycle observed in DRAIN.
  - Minimum 2 cycles after the last rd fall.
- Reset mid-session returns immediately to IDLE with everything cleared; no done pulse.

Optional Feature:
- Macro: STROBE_TXN_GAP_STATS_EN.
- Defined:
  - Extra outputs min_wr_gap and max_wr_gap (CNT_W each).
  - They hold the min/max cycles between consecutive `wr` rises in the session.
  - Initial values at start: min=all-ones, max=0; counting saturates.
  - Updated from the second write onward.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package strobe_txn_pkg:
  - typedef enum state_e {IDLE, ACTIVE, DRAIN, DONE, ERROR}.
  - Error bit index localparams ERR_WR_LEN=0, ERR_RD_LEN=1, ERR_EXTRA=2, ERR_TIMEOUT=3.
- One natural sub-module, strobe_edge_det:
  - Registers one input and outputs rise, fall and a saturating run-length count.
  - Instantiated for wr and rd.

Test Plan:
- Nominal session: start; 5 single-cycle wr pulses with gaps of 1–3 cycles; 5 rd bursts of 2 cycles, concurrent → wr_cnt=5, rd_cnt=5, err=0, one done pulse 2 cycles after the last rd fall, busy low after.
- Bad rd length: third rd burst held 3 cycles → err=4'b0010, state ERROR, done never pulses, rd_cnt=2.
- Wr held high: second wr held 2 cycles → err[0]=1, wr_cnt=2, ERROR.
- Extra strobe: 6th wr rise before reads finish → err[2]=1, wr_cnt stays 5.
- Timeout: start then no strobes for 64 cycles → err=4'b1000 at cycle 64, ERROR; a following start re-enters ACTIVE with err=0.
- Reset mid-session: rst_n low after 3 writes → all outputs 0 asynchronously, no done; with STROBE_TXN_GAP_STATS_EN, gaps of 2, 3, 1 report min=1, max=3 in the nominal run.

Source files
------------

// File: rtl/strobe_txn_pkg.sv
// Shared types for the strobe transaction responder.
//   state_e     : responder session states
//   ERR_*       : bit positions inside the 4-bit sticky error vector
// Optional feature macro used by the other files: STROBE_TXN_GAP_STATS_EN
package strobe_txn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE,
    ERROR
  } state_e;

  localparam int ERR_WR_LEN  = 0;
  localparam int ERR_RD_LEN  = 1;
  localparam int ERR_EXTRA   = 2;
  localparam int ERR_TIMEOUT = 3;

endpackage

// File: rtl/strobe_txn_responder_if.sv
// Strobe bus between the initiator (master) and the responder (slave).
//   start, wr, rd              : initiator -> responder
//   done, busy, wr_cnt, rd_cnt : responder status
//   err[3:0]                   : sticky error flags
//   min_wr_gap, max_wr_gap     : only with STROBE_TXN_GAP_STATS_EN
interface strobe_txn_if #(
  parameter int CNT_W = 8
) ();

  logic             start;
  logic             wr;
  logic             rd;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [3:0]       err;
`ifdef STROBE_TXN_GAP_STATS_EN
  logic [CNT_W-1:0] min_wr_gap;
  logic [CNT_W-1:0] max_wr_gap;

  modport master (output start, wr, rd,
                  input  done, busy, wr_cnt, rd_cnt, err, min_wr_gap, max_wr_gap);
  modport slave  (input  start, wr, rd,
                  output done, busy, wr_cnt, rd_cnt, err, min_wr_gap, max_wr_gap);
`else
  modport master (output start, wr, rd,
                  input  done, busy, wr_cnt, rd_cnt, err);
  modport slave  (input  start, wr, rd,
                  output done, busy, wr_cnt, rd_cnt, err);
`endif

endinterface

// File: rtl/strobe_edge_det.sv
// Single-line strobe edge detector.
//   clk, rst_n : clock, async active-low reset
//   in         : strobe line
//   rise, fall : edge of the live input against the previous sample
//   run        : consecutive high samples up to the previous edge,
//                saturating at RUN_MAX (non-zero means the line was high
//                on the previous cycle)
module strobe_edge_det #(
  parameter int CNT_W   = 8,
  parameter int RUN_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] run
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] run_q, run_d;

  always_comb begin
    prev_d = in;
    run_d  = '0;
    if (in) begin
      run_d = (run_q >= CNT_W'(RUN_MAX)) ? run_q : run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  assign rise = in & ~prev_q;
  assign fall = ~in & prev_q;
  assign run  = run_q;

endmodule

// File: rtl/strobe_txn_responder.sv
// Receive-side checker/responder for the wr/rd strobe protocol.
//   clk, rst_n : clock, async active-low reset
//   bus        : strobe_txn_if.slave (start/wr/rd in; done/busy/counts/err out)
// Optional: STROBE_TXN_GAP_STATS_EN adds min/max idle cycles between wr rises.
//
// state  | meaning
// IDLE   | waiting for start, strobes ignored
// ACTIVE | counting writes/reads, checking lengths and timeout
// DRAIN  | quota met, waiting for both lines low
// DONE   | one-cycle done pulse
// ERROR  | violation seen, err held until next start
module strobe_txn_responder
  import strobe_txn_pkg::*;
#(
  parameter int NUM_WR  = 5,
  parameter int NUM_RD  = 5,
  parameter int RD_LEN  = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  strobe_txn_if.slave bus
);

  localparam logic [CNT_W-1:0] NUM_WR_C = CNT_W'(NUM_WR);
  localparam logic [CNT_W-1:0] NUM_RD_C = CNT_W'(NUM_RD);
  localparam logic [CNT_W-1:0] RD_LEN_C = CNT_W'(RD_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic             wr_rise, wr_fall, rd_rise, rd_fall;
  logic [CNT_W-1:0] wr_run, rd_run;

  strobe_edge_det #(.CNT_W(CNT_W), .RUN_MAX(2)) u_wr_det (
    .clk(clk), .rst_n(rst_n), .in(bus.wr),
    .rise(wr_rise), .fall(wr_fall), .run(wr_run)
  );

  strobe_edge_det #(.CNT_W(CNT_W), .RUN_MAX(RD_LEN + 1)) u_rd_det (
    .clk(clk), .rst_n(rst_n), .in(bus.rd),
    .rise(rd_rise), .fall(rd_fall), .run(rd_run)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, tmo_q, tmo_d;
  logic [3:0]       err_q, err_d;
  logic             done_q, done_d, busy_q, busy_d;
`ifdef STROBE_TXN_GAP_STATS_EN
  logic [CNT_W-1:0] gap_q, gap_d, min_q, min_d, max_q, max_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef STROBE_TXN_GAP_STATS_EN
    gap_d    = gap_q;
    min_d    = min_q;
    max_d    = max_q;
`endif
    case (state_q)
      IDLE, ERROR: begin
        if (bus.start) begin
          state_d  = ACTIVE;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          tmo_d    = '0;
          err_d    = '0;
`ifdef STROBE_TXN_GAP_STATS_EN
          gap_d    = '0;
          min_d    = '1;
          max_d    = '0;
`endif
        end
      end
      ACTIVE: begin
        if (wr_rise) begin
          if (wr_cnt_q == NUM_WR_C) err_d[ERR_EXTRA] = 1'b1;
          else                      wr_cnt_d = wr_cnt_q + 1'b1;
        end
        // wr high with a non-zero run means it was already high last cycle
        if (bus.wr && wr_run != '0) err_d[ERR_WR_LEN] = 1'b1;
        if (rd_rise && rd_cnt_q == NUM_RD_C) err_d[ERR_EXTRA] = 1'b1;
        if (rd_fall) begin
          if (rd_run != RD_LEN_C)       err_d[ERR_RD_LEN] = 1'b1;
          else if (rd_cnt_q != NUM_RD_C) rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (wr_rise || wr_fall || rd_rise || rd_fall) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) err_d[ERR_TIMEOUT] = 1'b1;
        end
`ifdef STROBE_TXN_GAP_STATS_EN
        // gap_q holds the idle cycles since the previous wr rise
        gap_d = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        if (wr_rise) begin
          gap_d = '0;
          if (wr_cnt_q != '0 && wr_cnt_q != NUM_WR_C) begin
            if (gap_q < min_q) min_d = gap_q;
            if (gap_q > max_q) max_d = gap_q;
          end
        end
`endif
        // ERROR wins over the quota transition
        if (err_d != '0)
          state_d = ERROR;
        else if (wr_cnt_d == NUM_WR_C && rd_cnt_d == NUM_RD_C)
          state_d = DRAIN;
      end
      DRAIN: begin
        // a rise here is flagged first, the ERROR move follows a cycle later
        if (err_q[2:0] != '0) begin
          state_d = ERROR;
        end else if (wr_rise || rd_rise) begin
          err_d[ERR_EXTRA] = 1'b1;
        end else if (!bus.wr && !bus.rd) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACTIVE) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef STROBE_TXN_GAP_STATS_EN
      gap_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef STROBE_TXN_GAP_STATS_EN
      gap_q    <= gap_d;
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.wr_cnt = wr_cnt_q;
  assign bus.rd_cnt = rd_cnt_q;
  assign bus.err    = err_q;
`ifdef STROBE_TXN_GAP_STATS_EN
  assign bus.min_wr_gap = min_q;
  assign bus.max_wr_gap = max_q;
`endif

endmodule

// File: tb/tb_strobe_txn_responder.sv
// Bench for strobe_txn_responder: table of per-cycle vectors plus hand-written
// timeout and mid-session reset sequences. Each vector's expected outputs are
// queued when its inputs are driven and compared after the consuming edge.
module tb_strobe_txn_responder;

  typedef struct {
    logic       start, wr, rd;
    logic       busy, done;
    logic [7:0] wr_cnt, rd_cnt;
    logic [3:0] err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  strobe_txn_if #(.CNT_W(8)) bus ();

  strobe_txn_responder #(
    .NUM_WR(5), .NUM_RD(5), .RD_LEN(2), .TIMEOUT(64), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_miscompare = 0;
  int   done_seen = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  function automatic void add(input logic s, w, r, b, d,
                              input int wc, rc, input logic [3:0] e);
    vec_t v;
    v.start = s; v.wr = w; v.rd = r; v.busy = b; v.done = d;
    v.wr_cnt = 8'(wc); v.rd_cnt = 8'(rc); v.err = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    if (act !== exp_v) begin
      n_miscompare++;
      $display("FAIL %s at vector %0d: got %h expected %h", name, n_vec, act, exp_v);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    bus.start = v.start; bus.wr = v.wr; bus.rd = v.rd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_miscompare++;
      $display("FAIL scoreboard empty at vector %0d: got 0 entries expected 1", n_vec);
    end else begin
      e = sb.pop_front();
      check("busy",   {7'd0, bus.busy}, {7'd0, e.busy});
      check("done",   {7'd0, bus.done}, {7'd0, e.done});
      check("wr_cnt", bus.wr_cnt, e.wr_cnt);
      check("rd_cnt", bus.rd_cnt, e.rd_cnt);
      check("err",    {4'd0, bus.err}, {4'd0, e.err});
    end
  endtask

  task automatic step_q(input logic s, w, r, b, d, input int wc, rc, input logic [3:0] e);
    vec_t v;
    v.start = s; v.wr = w; v.rd = r; v.busy = b; v.done = d;
    v.wr_cnt = 8'(wc); v.rd_cnt = 8'(rc); v.err = e;
    step(v);
  endtask

  initial begin
    bus.start = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;

    // nominal: wr rises idle gaps 2,3,1,2; five 2-cycle rd bursts
    //  s  w  r  busy done wr rd err
    add(1, 0, 0, 1, 0, 0, 0, 4'b0000);
    add(0, 1, 0, 1, 0, 1, 0, 4'b0000);
    add(0, 0, 1, 1, 0, 1, 0, 4'b0000);
    add(0, 0, 1, 1, 0, 1, 0, 4'b0000);
    add(0, 1, 0, 1, 0, 2, 1, 4'b0000);
    add(0, 0, 0, 1, 0, 2, 1, 4'b0000);
    add(0, 0, 1, 1, 0, 2, 1, 4'b0000);
    add(0, 0, 1, 1, 0, 2, 1, 4'b0000);
    add(0, 1, 0, 1, 0, 3, 2, 4'b0000);  // wr rise + rd fall together
    add(0, 0, 1, 1, 0, 3, 2, 4'b0000);
    add(0, 1, 1, 1, 0, 4, 2, 4'b0000);
    add(0, 0, 0, 1, 0, 4, 3, 4'b0000);
    add(0, 0, 1, 1, 0, 4, 3, 4'b0000);
    add(0, 1, 1, 1, 0, 5, 3, 4'b0000);
    add(0, 0, 0, 1, 0, 5, 4, 4'b0000);
    add(0, 0, 1, 1, 0, 5, 4, 4'b0000);
    add(0, 0, 1, 1, 0, 5, 4, 4'b0000);
    add(0, 0, 0, 1, 0, 5, 5, 4'b0000);  // last rd fall -> DRAIN
    add(0, 0, 0, 0, 1, 5, 5, 4'b0000);  // quiet -> done pulse
    add(0, 0, 0, 0, 0, 5, 5, 4'b0000);
    // bad rd length: third burst 3 cycles
    add(1, 0, 0, 1, 0, 0, 0, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 0, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 0, 4'b0000);
    add(0, 0, 0, 1, 0, 0, 1, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 1, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 1, 4'b0000);
    add(0, 0, 0, 1, 0, 0, 2, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 2, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 2, 4'b0000);
    add(0, 0, 1, 1, 0, 0, 2, 4'b0000);
    add(0, 0, 0, 0, 0, 0, 2, 4'b0010);
    add(0, 0, 0, 0, 0, 0, 2, 4'b0010);
    // wr held two cycles (restart from ERROR)
    add(1, 0, 0, 1, 0, 0, 0, 4'b0000);
    add(0, 1, 0, 1, 0, 1, 0, 4'b0000);
    add(0, 0, 0, 1, 0, 1, 0, 4'b0000);
    add(0, 1, 0, 1, 0, 2, 0, 4'b0000);
    add(0, 1, 0, 0, 0, 2, 0, 4'b0001);
    add(0, 0, 0, 0, 0, 2, 0, 4'b0001);
    // sixth wr rise before any read completes
    add(1, 0, 0, 1, 0, 0, 0, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      add(0, 1, 0, 1, 0, i, 0, 4'b0000);
      add(0, 0, 0, 1, 0, i, 0, 4'b0000);
    end
    add(0, 1, 0, 0, 0, 5, 0, 4'b0100);
    add(0, 0, 0, 0, 0, 5, 0, 4'b0100);

    #12;
    check("reset_busy",   {7'd0, bus.busy}, 8'd0);
    check("reset_done",   {7'd0, bus.done}, 8'd0);
    check("reset_wr_cnt", bus.wr_cnt, 8'd0);
    check("reset_rd_cnt", bus.rd_cnt, 8'd0);
    check("reset_err",    {4'd0, bus.err}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
`ifdef STROBE_TXN_GAP_STATS_EN
      if (i == 19) begin
        check("min_wr_gap", bus.min_wr_gap, 8'd1);
        check("max_wr_gap", bus.max_wr_gap, 8'd3);
      end
`endif
    end

    // timeout: 63 quiet cycles stay ACTIVE, the 64th flags err[3]
    step_q(1, 0, 0, 1, 0, 0, 0, 4'b0000);
    for (int i = 1; i < 64; i++) step_q(0, 0, 0, 1, 0, 0, 0, 4'b0000);
    step_q(0, 0, 0, 0, 0, 0, 0, 4'b1000);
    step_q(0, 0, 0, 0, 0, 0, 0, 4'b1000);
    step_q(1, 0, 0, 1, 0, 0, 0, 4'b0000);

    // mid-session reset after three writes
    step_q(0, 1, 0, 1, 0, 1, 0, 4'b0000);
    step_q(0, 0, 0, 1, 0, 1, 0, 4'b0000);
    step_q(0, 1, 0, 1, 0, 2, 0, 4'b0000);
    step_q(0, 0, 0, 1, 0, 2, 0, 4'b0000);
    step_q(0, 1, 0, 1, 0, 3, 0, 4'b0000);
    bus.wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   {7'd0, bus.busy}, 8'd0);
    check("mid_rst_wr_cnt", bus.wr_cnt, 8'd0);
    check("mid_rst_err",    {4'd0, bus.err}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step_q(0, 0, 0, 0, 0, 0, 0, 4'b0000);

    check("done_pulses", 8'(done_seen), 8'd1);
    check("sb_leftover", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
